// File: rtl/usb_pkg.sv
// usb_pkg: shared definitions for the USB serial transmit path.
//   tx_state_e          - frame sequencer state encoding
//   SYNC_DEFAULT        - default sync word that opens a frame
//   IDLE_LEVEL_DEFAULT  - default line level while no data is shifted
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_HUNT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GUARD = 3'd4,
    ST_TAIL  = 3'd5,
    ST_DONE  = 3'd6
  } tx_state_e;

  localparam logic [7:0] SYNC_DEFAULT       = 8'h01;
  localparam logic       IDLE_LEVEL_DEFAULT = 1'b0;

endpackage

// File: rtl/usb_tx_ser_if.sv
// usb_tx_ser_if: valid/ready word channel feeding the serial transmitter.
//   din     - word to transmit (DW bits)
//   din_vld - din holds a valid word
//   din_rdy - transmitter takes the word when din_vld & din_rdy
// master = word source, slave = transmitter.
interface usb_tx_ser_if #(
  parameter int DW = 8
);

  logic [DW-1:0] din;
  logic          din_vld;
  logic          din_rdy;

  modport master (output din, output din_vld, input din_rdy);
  modport slave  (input din, input din_vld, output din_rdy);

endinterface

// File: rtl/usb_ser_shift.sv
// usb_ser_shift: DW-bit load/rotate register with bit counter.
//   clk, rst   - clock, asynchronous active-low reset
//   load       - capture load_word and restart the bit counter
//   load_word  - word to capture
//   step       - present the next bit (rotate one place, advance counter)
//   cur_bit    - bit currently at the outgoing end (MSB or LSB per MSB_FIRST)
//   cnt_last   - counter sits on the last bit of the word
// The register rotates instead of shifting, so after DW steps it holds the
// loaded word again; the guard phase replays it without a second copy.
module usb_ser_shift
  import usb_pkg::*;
#(
  parameter int DW        = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_word,
  input  logic          step,
  output logic          cur_bit,
  output logic          cnt_last
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [DW-1:0] sr_r;
  logic [CW-1:0] cnt_r;
  logic [DW-1:0] rot_s;

  // Rotation toward the outgoing end; the sent bit wraps to the far end.
  always_comb begin
    if (MSB_FIRST) begin
      rot_s = {sr_r[DW-2:0], sr_r[DW-1]};
    end else begin
      rot_s = {sr_r[0], sr_r[DW-1:1]};
    end
  end

  assign cur_bit  = MSB_FIRST ? sr_r[DW-1] : sr_r[0];
  assign cnt_last = (cnt_r == CW'(DW - 1));

  // Word register and bit counter; load wins over step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r  <= '0;
      cnt_r <= '0;
    end else if (load) begin
      sr_r  <= load_word;
      cnt_r <= '0;
    end else if (step) begin
      sr_r  <= rot_s;
      cnt_r <= cnt_last ? '0 : cnt_r + CW'(1);
    end else begin
      sr_r  <= sr_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/usb_tx_ser.sv
// usb_tx_ser: serial frame transmitter for the USB link path.
//   clk, rst - clock, asynchronous active-low reset
//   fs       - frame request level
//   bus      - valid/ready word input (slave side); din_rdy is combinational
//   dout     - registered serial data, one bit per clk
//   fire     - registered, high while the line carries a frame (aligned with dout)
//   done     - registered one-cycle pulse at frame end
//   err      - registered one-cycle pulse when the source underruns
// A frame: hunt for SYNC, stream words gaplessly, replay the last word
// GUARD_WORDS times, hold IDLE_LEVEL for TAIL_BITS, then pulse done.
module usb_tx_ser
  import usb_pkg::*;
#(
  parameter int          DW          = 8,
  parameter logic [DW-1:0] SYNC      = DW'(SYNC_DEFAULT),
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int          GUARD_WORDS = 1,
  parameter int          TAIL_BITS   = 8,
  parameter logic        IDLE_LEVEL  = IDLE_LEVEL_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  usb_tx_ser_if.slave bus,
  output logic        dout,
  output logic        fire,
  output logic        done,
  output logic        err
);

  // Empty guard or tail phases are skipped outright.
  localparam tx_state_e AFTER_GUARD = (TAIL_BITS != 0) ? ST_TAIL : ST_DONE;
  localparam tx_state_e AFTER_DATA  = (GUARD_WORDS != 0) ? ST_GUARD : AFTER_GUARD;

  tx_state_e  state_r, state_s;
  logic [3:0] gcnt_r, gcnt_s;
  logic [7:0] tcnt_r, tcnt_s;
  logic       dout_r, dout_s;
  logic       fire_r, fire_s;
  logic       done_r, done_s;
  logic       err_r, err_s;
  logic       load_s, step_s, rdy_s;
  logic       cur_bit_s, cnt_last_s;

  usb_ser_shift #(
    .DW        (DW),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_word (bus.din),
    .step      (step_s),
    .cur_bit   (cur_bit_s),
    .cnt_last  (cnt_last_s)
  );

  assign bus.din_rdy = rdy_s;

  // Next state, counters and next output values.
  always_comb begin
    state_s = state_r;
    gcnt_s  = gcnt_r;
    tcnt_s  = tcnt_r;
    dout_s  = IDLE_LEVEL;
    fire_s  = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
    load_s  = 1'b0;
    step_s  = 1'b0;
    rdy_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        gcnt_s  = 4'd0;
        tcnt_s  = 8'd0;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (fs) begin
          state_s = ST_HUNT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_HUNT: begin
        // Dropping fs wins over a SYNC on the bus: ready stays low.
        if (!fs) begin
          state_s = ST_IDLE;
        end else begin
          rdy_s = 1'b1;
          if (bus.din_vld && (bus.din == SYNC)) begin
            load_s  = 1'b1;
            state_s = ST_SHIFT;
          end else begin
            state_s = ST_HUNT;
          end
        end
      end
      ST_SHIFT: begin
        dout_s = cur_bit_s;
        fire_s = 1'b1;
        if (cnt_last_s) begin
          // Word boundary: the only point where fs is looked at.
          if (fs) begin
            rdy_s = 1'b1;
            if (bus.din_vld) begin
              load_s  = 1'b1;
              state_s = ST_SHIFT;
            end else begin
              err_s   = 1'b1;
              step_s  = 1'b1;
              state_s = AFTER_DATA;
            end
          end else begin
            step_s  = 1'b1;
            state_s = AFTER_DATA;
          end
        end else begin
          step_s  = 1'b1;
          state_s = ST_SHIFT;
        end
      end
      ST_GUARD: begin
        dout_s = cur_bit_s;
        fire_s = 1'b1;
        step_s = 1'b1;
        if (cnt_last_s) begin
          if (gcnt_r == 4'(GUARD_WORDS - 1)) begin
            state_s = AFTER_GUARD;
          end else begin
            gcnt_s  = gcnt_r + 4'd1;
            state_s = ST_GUARD;
          end
        end else begin
          state_s = ST_GUARD;
        end
      end
      ST_TAIL: begin
        fire_s = 1'b1;
        if (tcnt_r == 8'(TAIL_BITS - 1)) begin
          state_s = ST_DONE;
        end else begin
          tcnt_s  = tcnt_r + 8'd1;
          state_s = ST_TAIL;
        end
      end
      ST_DONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      gcnt_r  <= 4'd0;
      tcnt_r  <= 8'd0;
      dout_r  <= IDLE_LEVEL;
      fire_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      gcnt_r  <= gcnt_s;
      tcnt_r  <= tcnt_s;
      dout_r  <= dout_s;
      fire_r  <= fire_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  assign dout = dout_r;
  assign fire = fire_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_usb_tx_ser.sv
// tb_usb_tx_ser: drives three differently configured transmitters with one
// shared word stream and compares each serial output with a stream built
// from the accepted words, the bit order, guard count and tail length.
module tb_usb_tx_ser;

  localparam bit MF_A   [3] = '{1'b1, 1'b0, 1'b1};
  localparam int GW_A   [3] = '{1, 0, 3};
  localparam int TB_A   [3] = '{8, 0, 5};
  localparam bit IDLE_A [3] = '{1'b0, 1'b0, 1'b1};

  logic       clk;
  logic       rst;
  logic       fs;
  logic [7:0] din;
  logic       din_vld;
  logic [2:0] rdy_v, dout_v, fire_v, done_v, err_v;

  int  vectors, miscompares;
  int  cyc;
  bit  mon_clr;
  int  sync_cyc;

  logic [7:0] stim_q[$];
  logic [7:0] data_q[$];
  bit         exp_q[$];

  bit obs_q     [3][$];
  int first_fire[3];
  int last_fire [3];
  int done_cnt  [3];
  int done_cyc  [3];
  int err_cnt   [3];
  int err_cyc   [3];
  int idle_bad  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  initial cyc = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    usb_tx_ser_if #(.DW(8)) bus_if ();
    assign bus_if.din     = din;
    assign bus_if.din_vld = din_vld;
    assign rdy_v[g]       = bus_if.din_rdy;

    usb_tx_ser #(
      .DW          (8),
      .SYNC        (8'h01),
      .MSB_FIRST   (MF_A[g]),
      .GUARD_WORDS (GW_A[g]),
      .TAIL_BITS   (TB_A[g]),
      .IDLE_LEVEL  (IDLE_A[g])
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .fs   (fs),
      .bus  (bus_if),
      .dout (dout_v[g]),
      .fire (fire_v[g]),
      .done (done_v[g]),
      .err  (err_v[g])
    );
  end

  // Observation of every instance, sampled mid-cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (mon_clr || !rst) begin
        obs_q[g].delete();
        first_fire[g] <= -1;
        last_fire[g]  <= -1;
        done_cnt[g]   <= 0;
        done_cyc[g]   <= -1;
        err_cnt[g]    <= 0;
        err_cyc[g]    <= -1;
        idle_bad[g]   <= 0;
      end else begin
        if (fire_v[g]) begin
          obs_q[g].push_back(dout_v[g]);
          if (first_fire[g] < 0) first_fire[g] <= cyc;
          last_fire[g] <= cyc;
        end else if (dout_v[g] !== IDLE_A[g]) begin
          idle_bad[g] <= idle_bad[g] + 1;
        end
        if (done_v[g]) begin
          done_cnt[g] <= done_cnt[g] + 1;
          done_cyc[g] <= cyc;
        end
        if (err_v[g]) begin
          err_cnt[g] <= err_cnt[g] + 1;
          err_cyc[g] <= cyc;
        end
      end
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit word_bit(input logic [7:0] w, input int b, input bit mf);
    int pos;
    pos = mf ? (7 - b) : b;
    return ((w >> pos) & 8'd1) != 8'd0;
  endfunction

  function automatic bit all_done();
    return (done_cnt[0] > 0) && (done_cnt[1] > 0) && (done_cnt[2] > 0);
  endfunction

  // Expected line contents while fire is high for configuration g.
  task automatic build_exp(input int g);
    exp_q.delete();
    if (data_q.size() > 0) begin
      foreach (data_q[i])
        for (int b = 0; b < 8; b++) exp_q.push_back(word_bit(data_q[i], b, MF_A[g]));
      for (int r = 0; r < GW_A[g]; r++)
        for (int b = 0; b < 8; b++) exp_q.push_back(word_bit(data_q[$], b, MF_A[g]));
      for (int t = 0; t < TB_A[g]; t++) exp_q.push_back(IDLE_A[g]);
    end
  endtask

  // Offer stim_q (n_junk hunt words, then SYNC and data) and close the frame.
  task automatic drive(input int n_junk, input bit underrun);
    int idx, budget;
    data_q.delete();
    for (int i = n_junk; i < stim_q.size(); i++) data_q.push_back(stim_q[i]);
    sync_cyc = -1;
    mon_clr  = 1'b1;
    repeat (2) @(negedge clk);
    mon_clr = 1'b0;
    idx    = 0;
    budget = 0;
    while (idx < stim_q.size() && budget < 200) begin
      @(negedge clk);
      fs      = 1'b1;
      din     = stim_q[idx];
      din_vld = (idx > n_junk) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (din_vld && rdy_v[0]) begin
        if (idx == n_junk) sync_cyc = cyc;
        idx++;
      end
      budget++;
    end
    if (idx < stim_q.size()) check_val("hs_timeout", idx, stim_q.size());
    if (data_q.size() == 0) begin
      @(negedge clk);
      fs      = 1'b0;
      din     = 8'h01;
      din_vld = 1'b1;
      #1;
      check_val("rdy_fs0", rdy_v, 3'b000);
      @(negedge clk);
      din_vld = 1'b0;
      repeat (20) @(negedge clk);
    end else begin
      @(negedge clk);
      din_vld = 1'b0;
      if (!underrun) fs = 1'b0;
      budget = 0;
      while (!all_done() && budget < 400) begin
        @(negedge clk);
        #1;
        if (err_v[0]) fs = 1'b0;
        budget++;
      end
      fs = 1'b0;
      if (!all_done()) check_val("done_timeout", budget, 0);
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic check_frames(input bit underrun);
    int nd;
    nd = data_q.size();
    for (int g = 0; g < 3; g++) begin
      build_exp(g);
      check_val($sformatf("len_%0d", g), obs_q[g].size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q[g].size(); i++)
        check_val($sformatf("bit_%0d_%0d", g, i), obs_q[g][i], exp_q[i]);
      check_val($sformatf("done_cnt_%0d", g), done_cnt[g], (nd > 0) ? 1 : 0);
      check_val($sformatf("err_cnt_%0d", g), err_cnt[g], (underrun && nd > 0) ? 1 : 0);
      check_val($sformatf("idle_lvl_%0d", g), idle_bad[g], 0);
      if (nd > 0) begin
        check_val($sformatf("latency_%0d", g), first_fire[g] - sync_cyc, 2);
        check_val($sformatf("fire_span_%0d", g), last_fire[g] - first_fire[g] + 1, exp_q.size());
        check_val($sformatf("done_at_%0d", g), done_cyc[g], last_fire[g] + 1);
        if (underrun)
          check_val($sformatf("err_at_%0d", g), err_cyc[g], first_fire[g] + 8 * nd - 1);
      end
    end
  endtask

  function automatic logic [23:0] packed_head(input int g, input int n);
    logic [23:0] v;
    v = 24'd0;
    for (int i = 0; i < n && i < obs_q[g].size(); i++) v = {v[22:0], obs_q[g][i]};
    return v;
  endfunction

  initial begin
    int n_junk, n_data, wait_cnt;
    bit ur;
    logic [7:0] w;
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b0;
    fs      = 1'b0;
    din     = 8'h00;
    din_vld = 1'b0;
    mon_clr = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check_val($sformatf("rst_out_%0d", g), {dout_v[g], fire_v[g], done_v[g], err_v[g]},
                {IDLE_A[g], 3'b000});
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Junk word before sync, one data word, fs dropped.
    stim_q = '{8'h55, 8'h01, 8'hA5};
    drive(1, 1'b0);
    check_frames(1'b0);
    check_val("t1_head", packed_head(0, 24), 24'h01A5A5);
    check_val("t1_fire32", obs_q[0].size(), 32);

    // LSB-first ordering, no guard and no tail on instance 1.
    stim_q = '{8'h01, 8'h80};
    drive(0, 1'b0);
    check_frames(1'b0);
    check_val("t2_head", packed_head(1, 16), 24'h008001);

    // Underrun right after the sync word.
    stim_q = '{8'h01};
    drive(0, 1'b1);
    check_frames(1'b1);

    // fs drops in hunt before any sync.
    stim_q = '{8'h55, 8'hA0};
    drive(2, 1'b0);
    check_frames(1'b0);

    // Reset in the middle of the second word.
    fs = 1'b1; din = 8'h01; din_vld = 1'b1;
    wait_cnt = 0;
    do begin @(negedge clk); #1; wait_cnt++; end while (!rdy_v[0] && wait_cnt < 50);
    @(negedge clk);
    din = 8'hFF;
    wait_cnt = 0;
    do begin @(negedge clk); #1; wait_cnt++; end while (!fire_v[0] && wait_cnt < 50);
    check_val("rst_fire_seen", fire_v[0], 1);
    repeat (11) @(negedge clk);
    #1;
    check_val("pre_rst_dout", dout_v[0], 1);
    #1;
    rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      check_val($sformatf("mid_rst_%0d", g), {dout_v[g], fire_v[g], done_v[g], err_v[g]},
                {IDLE_A[g], 3'b000});
    fs = 1'b0; din_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check_val($sformatf("post_rst_%0d", g), obs_q[g].size() + done_cnt[g] + err_cnt[g], 0);

    // Randomised frames.
    repeat (12) begin
      n_junk = $urandom_range(0, 3);
      n_data = $urandom_range(1, 4);
      ur     = ($urandom_range(0, 1) != 0);
      stim_q.delete();
      for (int i = 0; i < n_junk; i++) begin
        do w = 8'($urandom); while (w == 8'h01);
        stim_q.push_back(w);
      end
      stim_q.push_back(8'h01);
      for (int i = 1; i < n_data; i++) stim_q.push_back(8'($urandom));
      drive(n_junk, ur);
      check_frames(ur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
